// File: rtl/exu_pkg.sv
// exu_pkg: definitions shared by the integer execution units.
//   DEFAULT_XLEN   default operand/result width
//   TRUE / FALSE   single-bit constants
//   CALC_*         4-bit calc-code space (0..15). The code port is wider;
//                  any code with bits set above bit 3 produces 0.
package exu_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [3:0] CALC_ADD  = 4'd0;
    localparam logic [3:0] CALC_SUB  = 4'd1;
    localparam logic [3:0] CALC_SLL  = 4'd2;
    localparam logic [3:0] CALC_SLT  = 4'd3;
    localparam logic [3:0] CALC_SLTU = 4'd4;
    localparam logic [3:0] CALC_XOR  = 4'd5;
    localparam logic [3:0] CALC_SRL  = 4'd6;
    localparam logic [3:0] CALC_SRA  = 4'd7;
    localparam logic [3:0] CALC_OR   = 4'd8;
    localparam logic [3:0] CALC_AND  = 4'd9;
    localparam logic [3:0] CALC_EQ   = 4'd10;
    localparam logic [3:0] CALC_NE   = 4'd11;
    localparam logic [3:0] CALC_LT   = 4'd12;
    localparam logic [3:0] CALC_GE   = 4'd13;
    localparam logic [3:0] CALC_LTU  = 4'd14;
    localparam logic [3:0] CALC_GEU  = 4'd15;

endpackage

// File: rtl/alu_calc.sv
// alu_calc: purely combinational integer ALU. Shared with the branch unit.
// Parameters: XLEN (power of two >= 8), CODE_W (calc-code width).
// Ports:
//   code    in  CODE_W  operation (see exu_pkg CALC_*)
//   lhs     in  XLEN    left operand
//   rhs     in  XLEN    right operand; shifts use only rhs[$clog2(XLEN)-1:0]
//   result  out XLEN    result; compares give zero-extended 0/1
module alu_calc
    import exu_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int CODE_W = 5
) (
    input  logic [CODE_W-1:0] code,
    input  logic [XLEN-1:0]   lhs,
    input  logic [XLEN-1:0]   rhs,
    output logic [XLEN-1:0]   result
);

    localparam int SH_W = $clog2(XLEN);

    logic [3:0]      op;
    logic            op_valid;
    logic [SH_W-1:0] shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;

    // Codes with any bit set above bit 3 fall outside the defined space.
    assign op       = 4'(code);
    assign op_valid = ((code >> 4) == '0);
    assign shamt    = rhs[SH_W-1:0];
    assign lt_s     = $signed(lhs) < $signed(rhs);
    assign lt_u     = lhs < rhs;
    assign eq       = lhs == rhs;

    always_comb begin
        result = '0;
        if (op_valid) begin
            case (op)
                CALC_ADD:           result = lhs + rhs;
                CALC_SUB:           result = lhs - rhs;
                CALC_SLL:           result = lhs << shamt;
                CALC_SLT, CALC_LT:  result = XLEN'(lt_s);
                CALC_SLTU, CALC_LTU: result = XLEN'(lt_u);
                CALC_XOR:           result = lhs ^ rhs;
                CALC_SRL:           result = lhs >> shamt;
                CALC_SRA:           result = $unsigned($signed(lhs) >>> shamt);
                CALC_OR:            result = lhs | rhs;
                CALC_AND:           result = lhs & rhs;
                CALC_EQ:            result = XLEN'(eq);
                CALC_NE:            result = XLEN'(!eq);
                CALC_GE:            result = XLEN'(!lt_s);
                CALC_GEU:           result = XLEN'(!lt_u);
                default:            result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_buffered_exu.sv
// alu_buffered_exu: single-cycle integer execution unit with a DEPTH-entry
// in-order result FIFO. Operations are accepted in the update phase
// (update_stat=1) and one result per write phase (update_stat=0) is written
// back into the instruction queue.
// Optional feature: define ALU_EXU_PERF_EN to add the saturating
// perf_issue_cnt_out / perf_full_cnt_out counters.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   rdy / chip_enable        global ready in, registered copy out; all
//                            state is frozen while chip_enable is low
//   update_stat              1 = accept phase (push), 0 = write phase (pop)
//   clear_flag_in            misprediction flush, wins over push and pop
//   rs_full_out              FIFO holds DEPTH entries
//   rs_calc_*_in, rs_lhs_in, rs_rhs_in, rs_pos_in_iq_in
//                            issue strobe, operation, operands, IQ tag
//   iq_write_*               one-cycle write-back strobe, index, field
//                            enables, result and field values
//   perf_*_cnt_out           performance counters (ALU_EXU_PERF_EN only)
module alu_buffered_exu
    import exu_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int IQ_ADDR_W = 5,
    parameter int CODE_W    = 5,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    output logic                 chip_enable,
    input  logic                 update_stat,
    input  logic                 clear_flag_in,
    output logic                 rs_full_out,
    input  logic                 rs_calc_enable_in,
    input  logic [CODE_W-1:0]    rs_calc_code_in,
    input  logic [XLEN-1:0]      rs_lhs_in,
    input  logic [XLEN-1:0]      rs_rhs_in,
    input  logic [IQ_ADDR_W-1:0] rs_pos_in_iq_in,
    output logic                 iq_write_enable_out,
    output logic [IQ_ADDR_W-1:0] iq_write_idx_out,
    output logic                 iq_write_result_enable_out,
    output logic                 iq_write_ready_enable_out,
    output logic                 iq_write_need_cdb_enable_out,
    output logic [XLEN-1:0]      iq_write_result_out,
    output logic                 iq_write_ready_out,
    output logic                 iq_write_need_cdb_out
`ifdef ALU_EXU_PERF_EN
    ,
    output logic [31:0]          perf_issue_cnt_out,
    output logic [31:0]          perf_full_cnt_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [XLEN-1:0]      res_mem [DEPTH];
    logic [IQ_ADDR_W-1:0] tag_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  calc_result;
    logic             issue_req;
    logic             do_flush;
    logic             do_push;
    logic             do_pop;

    alu_calc #(
        .XLEN   (XLEN),
        .CODE_W (CODE_W)
    ) u_alu_calc (
        .code   (rs_calc_code_in),
        .lhs    (rs_lhs_in),
        .rhs    (rs_rhs_in),
        .result (calc_result)
    );

    assign rs_full_out = (count == DEPTH_C);
    assign issue_req   = chip_enable & update_stat & rs_calc_enable_in & !clear_flag_in;
    assign do_flush    = chip_enable & clear_flag_in;
    // An issue while full is silently dropped; the RS is expected to watch rs_full_out.
    assign do_push     = issue_req & !rs_full_out;
    assign do_pop      = chip_enable & !update_stat & !clear_flag_in & (count != '0);

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            res_mem[tail] <= calc_result;
            tag_mem[tail] <= rs_pos_in_iq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chip_enable                  <= FALSE;
            head                         <= '0;
            tail                         <= '0;
            count                        <= '0;
            iq_write_enable_out          <= FALSE;
            iq_write_idx_out             <= '0;
            iq_write_result_enable_out   <= FALSE;
            iq_write_ready_enable_out    <= FALSE;
            iq_write_need_cdb_enable_out <= FALSE;
            iq_write_result_out          <= '0;
            iq_write_ready_out           <= FALSE;
            iq_write_need_cdb_out        <= FALSE;
        end else begin
            chip_enable <= rdy;
            if (chip_enable) begin
                // Enables default low each enabled cycle; data outputs hold.
                iq_write_enable_out          <= FALSE;
                iq_write_result_enable_out   <= FALSE;
                iq_write_ready_enable_out    <= FALSE;
                iq_write_need_cdb_enable_out <= FALSE;
                if (do_flush) begin
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                end else if (do_push) begin
                    tail  <= tail + PTR_W'(1);
                    count <= count + CNT_W'(1);
                end else if (do_pop) begin
                    iq_write_enable_out          <= TRUE;
                    iq_write_idx_out             <= tag_mem[head];
                    iq_write_result_enable_out   <= TRUE;
                    iq_write_ready_enable_out    <= TRUE;
                    iq_write_need_cdb_enable_out <= TRUE;
                    iq_write_result_out          <= res_mem[head];
                    iq_write_ready_out           <= TRUE;
                    iq_write_need_cdb_out        <= TRUE;
                    head  <= head + PTR_W'(1);
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

`ifdef ALU_EXU_PERF_EN
    // Counters survive a flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt_out <= '0;
            perf_full_cnt_out  <= '0;
        end else begin
            if (do_push && perf_issue_cnt_out != '1) begin
                perf_issue_cnt_out <= perf_issue_cnt_out + 32'd1;
            end
            if (issue_req && rs_full_out && perf_full_cnt_out != '1) begin
                perf_full_cnt_out <= perf_full_cnt_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_buffered_exu.sv
// tb_alu_buffered_exu: directed, scoreboard-based bench for alu_buffered_exu.
// Expected write-backs are queued when an issue is accepted by the bench's
// own model and compared when a write phase should produce them.
// Perf counters are checked when ALU_EXU_PERF_EN is defined.
module tb_alu_buffered_exu;
    import exu_pkg::*;

    localparam int XLEN      = 32;
    localparam int IQ_ADDR_W = 5;
    localparam int CODE_W    = 5;
    localparam int DEPTH     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rdy;
    logic                 chip_enable;
    logic                 update_stat;
    logic                 clear_flag_in;
    logic                 rs_full_out;
    logic                 rs_calc_enable_in;
    logic [CODE_W-1:0]    rs_calc_code_in;
    logic [XLEN-1:0]      rs_lhs_in;
    logic [XLEN-1:0]      rs_rhs_in;
    logic [IQ_ADDR_W-1:0] rs_pos_in_iq_in;
    logic                 iq_write_enable_out;
    logic [IQ_ADDR_W-1:0] iq_write_idx_out;
    logic                 iq_write_result_enable_out;
    logic                 iq_write_ready_enable_out;
    logic                 iq_write_need_cdb_enable_out;
    logic [XLEN-1:0]      iq_write_result_out;
    logic                 iq_write_ready_out;
    logic                 iq_write_need_cdb_out;
`ifdef ALU_EXU_PERF_EN
    logic [31:0]          perf_issue_cnt_out;
    logic [31:0]          perf_full_cnt_out;
`endif

    always #5 clk = ~clk;

    alu_buffered_exu #(
        .XLEN      (XLEN),
        .IQ_ADDR_W (IQ_ADDR_W),
        .CODE_W    (CODE_W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .rdy                          (rdy),
        .chip_enable                  (chip_enable),
        .update_stat                  (update_stat),
        .clear_flag_in                (clear_flag_in),
        .rs_full_out                  (rs_full_out),
        .rs_calc_enable_in            (rs_calc_enable_in),
        .rs_calc_code_in              (rs_calc_code_in),
        .rs_lhs_in                    (rs_lhs_in),
        .rs_rhs_in                    (rs_rhs_in),
        .rs_pos_in_iq_in              (rs_pos_in_iq_in),
        .iq_write_enable_out          (iq_write_enable_out),
        .iq_write_idx_out             (iq_write_idx_out),
        .iq_write_result_enable_out   (iq_write_result_enable_out),
        .iq_write_ready_enable_out    (iq_write_ready_enable_out),
        .iq_write_need_cdb_enable_out (iq_write_need_cdb_enable_out),
        .iq_write_result_out          (iq_write_result_out),
        .iq_write_ready_out           (iq_write_ready_out),
        .iq_write_need_cdb_out        (iq_write_need_cdb_out)
`ifdef ALU_EXU_PERF_EN
        ,
        .perf_issue_cnt_out           (perf_issue_cnt_out),
        .perf_full_cnt_out            (perf_full_cnt_out)
`endif
    );

    typedef struct packed {
        logic [IQ_ADDR_W-1:0] tag;
        logic [XLEN-1:0]      res;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_issue = 0;
    int   exp_full = 0;
    logic ce_exp = 1'b0;
    logic ce_edge = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference for the calc codes.
    function automatic logic [31:0] model(input int c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]         sh;
        logic signed [31:0] sa;
        logic signed [31:0] sb_s;
        sh   = b[4:0];
        sa   = a;
        sb_s = b;
        case (c)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return (sa < sb_s) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return sa >>> sh;
            8:  return a | b;
            9:  return a & b;
            10: return (a == b) ? 32'd1 : 32'd0;
            11: return (a != b) ? 32'd1 : 32'd0;
            12: return (sa < sb_s) ? 32'd1 : 32'd0;
            13: return (sa >= sb_s) ? 32'd1 : 32'd0;
            14: return (a < b) ? 32'd1 : 32'd0;
            15: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        ce_edge = ce_exp;
        @(posedge clk);
        ce_exp = rst ? 1'b0 : rdy;
        #1;
    endtask

    task automatic issue(input int code, input logic [31:0] a, input logic [31:0] b,
                         input int tag, input logic [31:0] exp_res);
        exp_t e;
        update_stat       = 1'b1;
        rs_calc_enable_in = 1'b1;
        rs_calc_code_in   = CODE_W'(code);
        rs_lhs_in         = a;
        rs_rhs_in         = b;
        rs_pos_in_iq_in   = IQ_ADDR_W'(tag);
        step();
        if (ce_edge && !clear_flag_in) begin
            if (sb.size() < DEPTH) begin
                e.tag = IQ_ADDR_W'(tag);
                e.res = exp_res;
                sb.push_back(e);
                exp_issue++;
            end else begin
                exp_full++;
            end
        end
        rs_calc_enable_in = 1'b0;
        chk("issue_no_strobe", 32'(iq_write_enable_out), 32'd0);
        chk("issue_full", 32'(rs_full_out), (sb.size() == DEPTH) ? 32'd1 : 32'd0);
    endtask

    task automatic write_phase(input string tag);
        exp_t e;
        update_stat = 1'b0;
        step();
        if (ce_edge && !clear_flag_in && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_strobe"}, 32'(iq_write_enable_out), 32'd1);
            chk({tag, "_idx"}, 32'(iq_write_idx_out), 32'(e.tag));
            chk({tag, "_result"}, iq_write_result_out, e.res);
            chk({tag, "_flags"},
                32'({iq_write_result_enable_out, iq_write_ready_enable_out,
                     iq_write_need_cdb_enable_out, iq_write_ready_out, iq_write_need_cdb_out}),
                32'h1f);
        end else begin
            chk({tag, "_no_strobe"}, 32'(iq_write_enable_out), 32'd0);
            chk({tag, "_no_res_en"}, 32'(iq_write_result_enable_out), 32'd0);
        end
        update_stat = 1'b1;
    endtask

    task automatic check_perf(input string tag);
`ifdef ALU_EXU_PERF_EN
        chk({tag, "_perf_issue"}, perf_issue_cnt_out, 32'(exp_issue));
        chk({tag, "_perf_full"}, perf_full_cnt_out, 32'(exp_full));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        rst               = 1'b1;
        rdy               = 1'b0;
        update_stat       = 1'b1;
        clear_flag_in     = 1'b0;
        rs_calc_enable_in = 1'b0;
        rs_calc_code_in   = '0;
        rs_lhs_in         = '0;
        rs_rhs_in         = '0;
        rs_pos_in_iq_in   = '0;
        repeat (3) step();

        // Reset state
        chk("rst_chip_enable", 32'(chip_enable), 32'd0);
        chk("rst_strobe", 32'(iq_write_enable_out), 32'd0);
        chk("rst_idx", 32'(iq_write_idx_out), 32'd0);
        chk("rst_result", iq_write_result_out, 32'd0);
        chk("rst_flags",
            32'({iq_write_result_enable_out, iq_write_ready_enable_out,
                 iq_write_need_cdb_enable_out, iq_write_ready_out, iq_write_need_cdb_out}),
            32'd0);
        chk("rst_full", 32'(rs_full_out), 32'd0);
        check_perf("rst");

        rst = 1'b0;
        rdy = 1'b1;
        step();
        chk("ce_after_rdy", 32'(chip_enable), 32'd1);
        step();

        // Basic add, then an empty write phase
        issue(0, 32'd5, 32'd7, 3, 32'd12);
        write_phase("add");
        write_phase("empty");
        chk("hold_result", iq_write_result_out, 32'd12);

        // Fill to DEPTH, two dropped issues, drain in order
        for (int i = 0; i < 6; i++) begin
            issue(0, 32'(i * 16), 32'd1, 8 + i, 32'(i * 16 + 1));
        end
        chk("full_after_fill", 32'(rs_full_out), 32'd1);
        check_perf("full");
        write_phase("drain0");
        chk("not_full_after_pop", 32'(rs_full_out), 32'd0);
        for (int i = 1; i < 5; i++) write_phase("drain");

        // Boundary operations
        issue(2, 32'd1, 32'h0000_0021, 1, 32'd2);
        issue(7, 32'h8000_0000, 32'd4, 2, 32'hF800_0000);
        issue(4, 32'd1, 32'hFFFF_FFFF, 3, 32'd1);
        issue(20, 32'd5, 32'd7, 4, 32'd0);
        write_phase("sll");
        write_phase("sra");
        write_phase("sltu");
        write_phase("code20");
        issue(1, 32'd0, 32'd1, 5, 32'hFFFF_FFFF);
        write_phase("sub_wrap");

        // All codes, both operand orders; rhs shift field has upper bits set
        for (int c = 0; c < 16; c++) begin
            issue(c, 32'hFFFF_FFFD, 32'h0000_0025, c, model(c, 32'hFFFF_FFFD, 32'h0000_0025));
            write_phase("sweep_a");
            issue(c, 32'h0000_0025, 32'hFFFF_FFFD, c + 16, model(c, 32'h0000_0025, 32'hFFFF_FFFD));
            write_phase("sweep_b");
        end

        // Flush during a write phase with 3 entries queued
        issue(0, 32'd1, 32'd2, 1, 32'd3);
        issue(0, 32'd3, 32'd4, 2, 32'd7);
        issue(0, 32'd5, 32'd6, 3, 32'd11);
        update_stat   = 1'b0;
        clear_flag_in = 1'b1;
        step();
        chk("flush_no_strobe", 32'(iq_write_enable_out), 32'd0);
        chk("flush_not_full", 32'(rs_full_out), 32'd0);
        if (ce_edge) sb.delete();
        clear_flag_in = 1'b0;
        update_stat   = 1'b1;
        write_phase("post_flush_empty");
        clear_flag_in = 1'b1;
        issue(0, 32'd9, 32'd9, 6, 32'd18);
        clear_flag_in = 1'b0;
        write_phase("flush_blocks_push");
        issue(0, 32'd100, 32'd1, 9, 32'd101);
        write_phase("post_flush_new");
        write_phase("post_flush_none");

        // rdy low freezes the unit
        issue(0, 32'd1, 32'd1, 7, 32'd2);
        rdy = 1'b0;
        step();
        chk("ce_low", 32'(chip_enable), 32'd0);
        write_phase("frozen_write");
        issue(0, 32'd50, 32'd50, 12, 32'd100);
        rdy = 1'b1;
        step();
        chk("ce_back", 32'(chip_enable), 32'd1);
        write_phase("unfrozen");
        write_phase("unfrozen_empty");
        check_perf("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_buffered_exu.md
# alu_buffered_exu

Parametrised integer execution unit for the out-of-order RISC-V core: accepts operations from the ALU reservation station in the update phase, computes them in one cycle, and holds results in a DEPTH-entry in-order result FIFO. In each write phase it drains one result into the instruction queue. It supersedes the single-slot ALU, adding configurable width and depth, a flush path, masked shift amounts and a one-cycle write strobe.

## Interface
- XLEN, 32, operand/result width; power of two ≥ 8
- IQ_ADDR_W, 5, instruction-queue index width
- CODE_W, 5, calc-code width; codes 0–15 defined
- DEPTH, 4, result FIFO entries; power of two ≥ 2
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; registered into chip_enable
- chip_enable  out  1  registered rdy; all state frozen while low
- update_stat  in  1  high = accept phase (push); low = write phase (pop)
- clear_flag_in  in  1  misprediction flush
- rs_full_out  out  1  FIFO count == DEPTH
- rs_calc_enable_in  in  1  issue strobe
- rs_calc_code_in  in  CODE_W  operation
- rs_lhs_in, rs_rhs_in  in  XLEN  operands
- rs_pos_in_iq_in  in  IQ_ADDR_W  destination IQ index
- iq_write_enable_out  out  1  one-cycle write strobe
- iq_write_idx_out  out  IQ_ADDR_W  target index
- iq_write_result_enable_out, iq_write_ready_enable_out, iq_write_need_cdb_enable_out  out  1 each  field enables
- iq_write_result_out  out  XLEN  result
- iq_write_ready_out, iq_write_need_cdb_out  out  1 each  field values
- perf_issue_cnt_out, perf_full_cnt_out  out  32 each  present only with ALU_EXU_PERF_EN

## Operation
- Reset: chip_enable=0; count, head, tail = 0; every iq_write_* output = 0; perf counters = 0.
- Push occurs when chip_enable & update_stat & rs_calc_enable_in & !clear_flag_in & count<DEPTH. It stores {result, rs_pos_in_iq_in} at tail; tail++.
- An issue while full is dropped. State is unchanged. RS must honour rs_full_out.
- Pop occurs when chip_enable & !update_stat & !clear_flag_in & count>0. It drives iq_write_idx_out = head tag and iq_write_result_out = head result. All six enable/value bits are driven to 1. Then head++.
- Any other enabled cycle drives iq_write_enable_out and the three *_enable_out bits to 0. Data outputs hold their last value.
- Flush: chip_enable & clear_flag_in sets count=0 and head=tail=0, deasserts all enables, and blocks any push or pop that cycle. It takes priority in either phase.
- Calc codes: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 eq, 11 ne, 12 lt, 13 ge, 14 ltu, 15 geu. Codes ≥16 give 0.
- Shift amount = rhs[$clog2(XLEN)-1:0]. Upper bits are ignored.
- Compare results are zero-extended 0/1. Add/sub wrap modulo 2^XLEN.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.

## Timing
- Result latency: a push at update edge t pops at the first non-update edge after t. iq_write_* are valid in the cycle that follows that edge.
- Push and pop never share an edge, because of phase exclusivity. Throughput is one op per update/write phase pair.
- rs_full_out is registered-derived and valid the cycle after the push that fills the FIFO.
- rdy low: chip_enable falls one edge later. Outputs hold while chip_enable=0.

## Configuration
- ALU_EXU_PERF_EN defined: perf_issue_cnt_out increments on every push. perf_full_cnt_out increments on every enabled update-phase cycle with rs_calc_enable_in while full. Both are saturating at 2^32-1, cleared by rst only, and not by flush.
- ALU_EXU_PERF_EN undefined: these ports and counters are absent.

## Structure
- Shared package exu_pkg holds:
  - calc-code localparams (CALC_ADD=0 … CALC_GEU=15)
  - default XLEN
  - True/False constants
- Sub-module alu_calc: purely combinational (code, lhs, rhs) → result, parametrised by XLEN and CODE_W, and reused by the branch unit.
- FIFO storage and control stay inline.

## Test plan
- Reset then idle: all iq_write_* = 0, rs_full_out=0, chip_enable=1 one edge after rdy=1.
- Issue add 5+7 tag 3, then one write phase: strobe for one cycle with idx=3, result=12, all flags 1. The next write phase with an empty FIFO gives strobe 0.
- Issue 4 ops, DEPTH=4, with no write phase between (update held high): rs_full_out=1. A fifth issue is dropped. Four write phases return the results in order. The fifth does not appear.
- sll 1 by rhs=0x21 (XLEN=32) → 2. sra 0x80000000 by 4 → 0xF8000000. sltu 1 vs 0xFFFFFFFF → 1. Code 20 → 0.
- 3 entries queued, assert clear_flag_in during a write phase: no strobe, count 0. A new issue afterwards returns only the new result.
- Perf build: 6 issues against DEPTH=4 with no drains gives perf_issue_cnt_out=4 and perf_full_cnt_out=2.
